// File: rtl/jrc_pkg.sv
// Shared types and code-checking helpers for the Johnson/ring decoder.
// The helpers work on a zero-extended code of up to CODE_MAX_W bits. The
// argument n gives the real code width, so one set of functions serves any N.
package jrc_pkg;

   localparam int CODE_MAX_W = 32;

   typedef enum logic [1:0] {
      ACQUIRE,
      TRACK,
      LOCKED
   } lock_state_e;

   typedef enum logic [1:0] {
      HOLD,
      ADV,
      BAD,
      ILL
   } step_class_e;

   function automatic int popcount(input logic [CODE_MAX_W-1:0] code, input int n);
      int cnt;
      cnt = 0;
      for (int i = 0; i < CODE_MAX_W; i++) begin
         if (i < n && code[i]) cnt = cnt + 1;
      end
      return cnt;
   endfunction

   // A single run of ones anchored at either end has at most one 0/1 boundary
   // inside the word; all-zero and all-one have none.
   function automatic logic johnson_legal(input logic [CODE_MAX_W-1:0] code, input int n);
      int edges;
      edges = 0;
      for (int i = 1; i < CODE_MAX_W; i++) begin
         if (i < n && code[i] != code[i-1]) edges = edges + 1;
      end
      return (edges <= 1);
   endfunction

   function automatic int johnson_decode(input logic [CODE_MAX_W-1:0] code, input int n);
      int pc;
      pc = popcount(code, n);
      if (pc == 0)          return 0;
      else if (code[n-1])   return pc;
      else                  return 2 * n - pc;
   endfunction

   function automatic logic ring_legal(input logic [CODE_MAX_W-1:0] code, input int n);
      int pc;
      pc = popcount(code, n);
      return (pc > 0) && (pc < n);
   endfunction

   function automatic logic [CODE_MAX_W-1:0] rotl1(input logic [CODE_MAX_W-1:0] code, input int n);
      logic [CODE_MAX_W-1:0] res;
      res    = '0;
      res[0] = code[n-1];
      for (int i = 1; i < CODE_MAX_W; i++) begin
         if (i < n) res[i] = code[i-1];
      end
      return res;
   endfunction

endpackage

// File: rtl/jrc_lock_tracker.sv
// Per-channel lock qualifier. It takes the step class of each sample and
// keeps the lock state, the advance pulse and a saturating error count.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ACQUIRE | waiting for any legal code to start tracking
//   TRACK   | counting consecutive legal advances toward lock
//   LOCKED  | sequence qualified; BAD/ILL codes are counted as errors
module jrc_lock_tracker
   import jrc_pkg::*;
#(
   parameter int LOCK_CNT = 3,
   parameter int ERR_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_en,
   input  step_class_e       step_class,
   input  logic              err_clr,
   output lock_state_e       state,
   output logic              step,
   output logic [ERR_W-1:0]  err_cnt
);

   localparam int GW = $clog2(LOCK_CNT + 1);

   lock_state_e      state_q, state_d;
   logic [GW-1:0]    good_q, good_d;
   logic             step_q, step_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             err_hit;

   // Next lock state, good-advance count and step pulse from the sample class
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      step_d  = 1'b0;
      err_hit = 1'b0;
      if (sample_en) begin
         unique case (state_q)
            ACQUIRE: begin
               if (step_class != ILL) begin
                  state_d = TRACK;
                  good_d  = '0;
               end
            end
            TRACK: begin
               unique case (step_class)
                  ADV: begin
                     step_d = 1'b1;
                     if (good_q == GW'(LOCK_CNT - 1)) begin
                        state_d = LOCKED;
                        good_d  = GW'(LOCK_CNT);
                     end else begin
                        good_d = good_q + GW'(1);
                     end
                  end
                  BAD: good_d = '0;
                  ILL: begin
                     state_d = ACQUIRE;
                     good_d  = '0;
                  end
                  default: ;
               endcase
            end
            LOCKED: begin
               unique case (step_class)
                  ADV: step_d = 1'b1;
                  BAD: begin
                     err_hit = 1'b1;
                     state_d = TRACK;
                     good_d  = '0;
                  end
                  ILL: begin
                     err_hit = 1'b1;
                     state_d = ACQUIRE;
                     good_d  = '0;
                  end
                  default: ;
               endcase
            end
            default: state_d = ACQUIRE;
         endcase
      end
   end

   // Error counter: clear wins over a same-cycle error, otherwise saturate
   always_comb begin
      err_d = err_q;
      if (err_clr)                   err_d = '0;
      else if (err_hit && err_q != '1) err_d = err_q + ERR_W'(1);
   end

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACQUIRE;
         good_q  <= '0;
         step_q  <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         good_q  <= good_d;
         step_q  <= step_d;
         err_q   <= err_d;
      end
   end

   assign state   = state_q;
   assign step    = step_q;
   assign err_cnt = err_q;

endmodule

// File: rtl/johnson_ring_decoder.sv
// Receive-side checker for a Johnson/ring counter pair. It decodes the
// Johnson code to an index and tracks the ring rotation phase. Each sample
// is classified against the last legal code, and the result feeds one lock
// tracker per channel.
module johnson_ring_decoder
   import jrc_pkg::*;
#(
   parameter int N        = 4,
   parameter int LOCK_CNT = 3,
   parameter int ERR_W    = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sample_en,
   input  logic                    err_clr,
   input  logic [N-1:0]            j_code,
   input  logic [N-1:0]            r_code,
   output logic [$clog2(2*N)-1:0]  j_index,
   output logic                    j_code_ok,
   output logic                    j_step,
   output logic                    j_locked,
   output logic [ERR_W-1:0]        j_err_cnt,
   output logic [$clog2(N)-1:0]    r_phase,
   output logic                    r_step,
   output logic                    r_locked,
   output logic [ERR_W-1:0]        r_err_cnt
);

   localparam int JW = $clog2(2 * N);
   localparam int RW = $clog2(N);

   logic [N-1:0]          j_prev_q, j_prev_d;
   logic [N-1:0]          r_prev_q, r_prev_d;
   logic [JW-1:0]         j_index_q, j_index_d;
   logic                  j_ok_q, j_ok_d;
   logic [RW-1:0]         r_phase_q, r_phase_d;
   logic [CODE_MAX_W-1:0] j_code_x, j_prev_x, r_code_x, r_prev_x;
   logic                  j_legal, r_legal;
   int                    j_idx_new, j_idx_prev;
   step_class_e           j_cls, r_cls;
   lock_state_e           j_state, r_state;

   assign j_code_x = CODE_MAX_W'(j_code);
   assign j_prev_x = CODE_MAX_W'(j_prev_q);
   assign r_code_x = CODE_MAX_W'(r_code);
   assign r_prev_x = CODE_MAX_W'(r_prev_q);

   // Johnson classification: an advance is the next index modulo 2N, so the
   // wrap from 2N-1 back to 0 counts as an advance
   always_comb begin
      j_legal    = johnson_legal(j_code_x, N);
      j_idx_new  = johnson_decode(j_code_x, N);
      j_idx_prev = johnson_decode(j_prev_x, N);
      if (!j_legal)                                      j_cls = ILL;
      else if (j_code == j_prev_q)                       j_cls = HOLD;
      else if (j_idx_new == (j_idx_prev + 1) % (2 * N))  j_cls = ADV;
      else                                               j_cls = BAD;
   end

   // Ring classification: an advance is exactly one left rotation
   always_comb begin
      r_legal = ring_legal(r_code_x, N);
      if (!r_legal)                          r_cls = ILL;
      else if (r_code == r_prev_q)           r_cls = HOLD;
      else if (r_code_x == rotl1(r_prev_x, N)) r_cls = ADV;
      else                                   r_cls = BAD;
   end

   // Johnson stored code and index follow the last legal sample only
   always_comb begin
      j_prev_d  = j_prev_q;
      j_index_d = j_index_q;
      j_ok_d    = j_ok_q;
      if (sample_en) begin
         j_ok_d = j_legal;
         if (j_legal) begin
            j_prev_d  = j_code;
            j_index_d = JW'(j_idx_new);
         end
      end
   end

   // Ring phase restarts on acquisition or a bad jump and counts advances mod N
   always_comb begin
      r_prev_d  = r_prev_q;
      r_phase_d = r_phase_q;
      if (sample_en && r_legal) begin
         r_prev_d = r_code;
         if (r_state == ACQUIRE || r_cls == BAD) begin
            r_phase_d = '0;
         end else if (r_cls == ADV) begin
            r_phase_d = (r_phase_q == RW'(N - 1)) ? '0 : r_phase_q + RW'(1);
         end
      end
   end

   // Decode-side registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         j_prev_q  <= '0;
         r_prev_q  <= '0;
         j_index_q <= '0;
         j_ok_q    <= 1'b0;
         r_phase_q <= '0;
      end else begin
         j_prev_q  <= j_prev_d;
         r_prev_q  <= r_prev_d;
         j_index_q <= j_index_d;
         j_ok_q    <= j_ok_d;
         r_phase_q <= r_phase_d;
      end
   end

   jrc_lock_tracker #(
      .LOCK_CNT (LOCK_CNT),
      .ERR_W    (ERR_W)
   ) u_j_lock (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_en  (sample_en),
      .step_class (j_cls),
      .err_clr    (err_clr),
      .state      (j_state),
      .step       (j_step),
      .err_cnt    (j_err_cnt)
   );

   jrc_lock_tracker #(
      .LOCK_CNT (LOCK_CNT),
      .ERR_W    (ERR_W)
   ) u_r_lock (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_en  (sample_en),
      .step_class (r_cls),
      .err_clr    (err_clr),
      .state      (r_state),
      .step       (r_step),
      .err_cnt    (r_err_cnt)
   );

   assign j_index   = j_index_q;
   assign j_code_ok = j_ok_q;
   assign j_locked  = (j_state == LOCKED);
   assign r_phase   = r_phase_q;
   assign r_locked  = (r_state == LOCKED);

endmodule

// File: tb/tb_johnson_ring_decoder.sv
// Bench for johnson_ring_decoder (N=4, LOCK_CNT=3, ERR_W=8): directed
// scenarios plus randomized traffic, compared against a table-driven model.
module tb_johnson_ring_decoder;

   localparam int N        = 4;
   localparam int LOCK_CNT = 3;
   localparam int ERR_W    = 8;
   localparam int EMAX     = (1 << ERR_W) - 1;
   localparam int MASK     = (1 << N) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             sample_en = 1'b0;
   logic             err_clr = 1'b0;
   logic [N-1:0]     j_code = '0;
   logic [N-1:0]     r_code = '0;
   logic [2:0]       j_index;
   logic             j_code_ok, j_step, j_locked;
   logic [ERR_W-1:0] j_err_cnt;
   logic [1:0]       r_phase;
   logic             r_step, r_locked;
   logic [ERR_W-1:0] r_err_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   johnson_ring_decoder #(.N(N), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en),
      .err_clr   (err_clr),
      .j_code    (j_code),
      .r_code    (r_code),
      .j_index   (j_index),
      .j_code_ok (j_code_ok),
      .j_step    (j_step),
      .j_locked  (j_locked),
      .j_err_cnt (j_err_cnt),
      .r_phase   (r_phase),
      .r_step    (r_step),
      .r_locked  (r_locked),
      .r_err_cnt (r_err_cnt)
   );

   // Reference model. Lock states: 0 acquire, 1 track, 2 locked.
   // Classes: 0 hold, 1 advance, 2 bad, 3 illegal.
   int jtab[2*N];
   int mj_st, mj_good, mj_prev, mj_idx, mj_ok, mj_step, mj_err;
   int mr_st, mr_good, mr_prev, mr_phase, mr_step, mr_err;

   function automatic int jidx_of(input int c);
      for (int k = 0; k < 2 * N; k++) if (jtab[k] == c) return k;
      return -1;
   endfunction

   function automatic int rot(input int c);
      return ((c << 1) | (c >> (N - 1))) & MASK;
   endfunction

   task automatic model_reset();
      mj_st = 0; mj_good = 0; mj_prev = 0; mj_idx = 0; mj_ok = 0; mj_step = 0; mj_err = 0;
      mr_st = 0; mr_good = 0; mr_prev = 0; mr_phase = 0; mr_step = 0; mr_err = 0;
   endtask

   task automatic lock_upd(input int cls, inout int st, inout int good,
                           output int stp, output int inc);
      stp = 0; inc = 0;
      if (st == 0) begin
         if (cls != 3) begin st = 1; good = 0; end
      end else if (st == 1) begin
         if (cls == 1) begin
            stp = 1; good = good + 1;
            if (good >= LOCK_CNT) st = 2;
         end else if (cls == 2) good = 0;
         else if (cls == 3) begin st = 0; good = 0; end
      end else begin
         if (cls == 1) stp = 1;
         else if (cls >= 2) begin
            inc = 1; good = 0;
            st = (cls == 2) ? 1 : 0;
         end
      end
   endtask

   task automatic model_step(input bit se, input bit clr, input int j, input int r);
      int jx, jcls, rcls, jinc, rinc, rst_old, pc;
      jinc = 0; rinc = 0;
      mj_step = 0; mr_step = 0;
      if (se) begin
         jx = jidx_of(j);
         if (jx < 0)                                jcls = 3;
         else if (j == mj_prev)                     jcls = 0;
         else if (jx == (jidx_of(mj_prev) + 1) % (2 * N)) jcls = 1;
         else                                       jcls = 2;
         pc = $countones(r[N-1:0]);
         if (pc == 0 || pc == N)  rcls = 3;
         else if (r == mr_prev)   rcls = 0;
         else if (r == rot(mr_prev)) rcls = 1;
         else                     rcls = 2;
         lock_upd(jcls, mj_st, mj_good, mj_step, jinc);
         rst_old = mr_st;
         lock_upd(rcls, mr_st, mr_good, mr_step, rinc);
         mj_ok = (jx >= 0) ? 1 : 0;
         if (jx >= 0) begin mj_idx = jx; mj_prev = j; end
         if (rcls != 3) begin
            if (rst_old == 0 || rcls == 2) mr_phase = 0;
            else if (rcls == 1)            mr_phase = (mr_phase + 1) % N;
            mr_prev = r;
         end
      end
      if (clr) begin mj_err = 0; mr_err = 0; end
      else begin
         if (jinc != 0 && mj_err < EMAX) mj_err = mj_err + 1;
         if (rinc != 0 && mr_err < EMAX) mr_err = mr_err + 1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      checks = checks + 1;
      assert (obs === 32'(exp)) else begin
         failures = failures + 1;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ":j_index"},   32'(j_index),   mj_idx);
      chk({tag, ":j_code_ok"}, 32'(j_code_ok), mj_ok);
      chk({tag, ":j_step"},    32'(j_step),    mj_step);
      chk({tag, ":j_locked"},  32'(j_locked),  (mj_st == 2) ? 1 : 0);
      chk({tag, ":j_err_cnt"}, 32'(j_err_cnt), mj_err);
      chk({tag, ":r_phase"},   32'(r_phase),   mr_phase);
      chk({tag, ":r_step"},    32'(r_step),    mr_step);
      chk({tag, ":r_locked"},  32'(r_locked),  (mr_st == 2) ? 1 : 0);
      chk({tag, ":r_err_cnt"}, 32'(r_err_cnt), mr_err);
   endtask

   task automatic cyc(input bit se, input bit clr, input logic [N-1:0] j,
                      input logic [N-1:0] r, input string tag);
      sample_en = se; err_clr = clr; j_code = j; r_code = r;
      @(posedge clk); #1;
      model_step(se, clr, int'(j), int'(r));
      check_all(tag);
   endtask

   task automatic relock_j(input logic [N-1:0] r);
      cyc(1'b1, 1'b0, 4'b0000, r, "relock");
      cyc(1'b1, 1'b0, 4'b1000, r, "relock");
      cyc(1'b1, 1'b0, 4'b1100, r, "relock");
      cyc(1'b1, 1'b0, 4'b1110, r, "relock");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [N-1:0] jc, rc;
      int sel;
      bit se, clr;

      for (int k = 0; k < 2 * N; k++) begin
         if (k <= N) jtab[k] = ((1 << k) - 1) << (N - k);
         else        jtab[k] = (1 << (2 * N - k)) - 1;
      end
      model_reset();

      #12;
      check_all("reset");
      rst_n = 1'b1;

      // Lock both channels from scratch
      cyc(1'b1, 1'b0, 4'b0000, 4'b1010, "acq0");
      cyc(1'b1, 1'b0, 4'b1000, 4'b0101, "acq1");
      cyc(1'b1, 1'b0, 4'b1100, 4'b1010, "acq2");
      cyc(1'b1, 1'b0, 4'b1110, 4'b0101, "acq3");
      chk("j_locked_after_1110", 32'(j_locked), 1);
      chk("j_index_after_1110", 32'(j_index), 3);
      chk("r_phase_after_4", 32'(r_phase), 3);
      chk("r_locked_after_4", 32'(r_locked), 1);

      // Run through the rest of the Johnson cycle including the wrap
      cyc(1'b1, 1'b0, 4'b1111, 4'b1010, "run4");
      cyc(1'b1, 1'b0, 4'b0111, 4'b0101, "run5");
      cyc(1'b1, 1'b0, 4'b0011, 4'b1010, "run6");
      cyc(1'b1, 1'b0, 4'b0001, 4'b0101, "run7");
      cyc(1'b1, 1'b0, 4'b0000, 4'b1010, "wrap");
      chk("j_wrap_index", 32'(j_index), 0);
      chk("j_wrap_no_err", 32'(j_err_cnt), 0);

      // Illegal codes on both channels while locked
      cyc(1'b1, 1'b0, 4'b1010, 4'b1111, "inject");
      chk("inj_j_code_ok", 32'(j_code_ok), 0);
      chk("inj_j_err", 32'(j_err_cnt), 1);
      chk("inj_j_locked", 32'(j_locked), 0);
      chk("inj_j_index_held", 32'(j_index), 0);
      chk("inj_r_err", 32'(r_err_cnt), 1);
      chk("inj_r_locked", 32'(r_locked), 0);

      // Saturate the Johnson error counter
      for (int k = 0; k < 300 && mj_err < EMAX; k++) begin
         relock_j(4'b0011);
         cyc(1'b1, 1'b0, 4'b1010, 4'b0011, "sat");
      end
      chk("sat_reached", 32'(j_err_cnt), EMAX);
      relock_j(4'b0011);
      cyc(1'b1, 1'b0, 4'b1010, 4'b0011, "sat_extra");
      chk("sat_hold", 32'(j_err_cnt), EMAX);
      relock_j(4'b0011);
      cyc(1'b1, 1'b1, 4'b1010, 4'b0011, "clr_with_err");
      chk("clr_priority", 32'(j_err_cnt), 0);

      // Randomized traffic biased toward legal advances
      for (int k = 0; k < 400; k++) begin
         se  = ($urandom_range(0, 9) != 0);
         clr = ($urandom_range(0, 39) == 0);
         sel = $urandom_range(0, 9);
         if (sel < 6)      jc = 4'(jtab[(jidx_of(mj_prev) + 1) % (2 * N)]);
         else if (sel < 8) jc = 4'(mj_prev);
         else              jc = 4'($urandom_range(0, MASK));
         sel = $urandom_range(0, 9);
         if (sel < 6)      rc = 4'(rot(mr_prev));
         else if (sel < 8) rc = 4'(mr_prev);
         else              rc = 4'($urandom_range(0, MASK));
         cyc(se, clr, jc, rc, "rand");
      end

      // Relock, then idle with changing codes: state frozen, no pulses
      relock_j(4'b0110);
      for (int k = 0; k < 10; k++) begin
         jc = 4'($urandom_range(0, MASK));
         rc = 4'($urandom_range(0, MASK));
         cyc(1'b0, 1'b0, jc, rc, "idle");
         chk("idle_j_step", 32'(j_step), 0);
         chk("idle_r_step", 32'(r_step), 0);
      end

      // Asynchronous reset between clock edges
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      chk("async_rst_j_locked", 32'(j_locked), 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b1, 1'b0, 4'b1110, 4'b1000, "post_rst0");
      cyc(1'b1, 1'b0, 4'b1111, 4'b0001, "post_rst1");
      cyc(1'b1, 1'b0, 4'b0111, 4'b0010, "post_rst2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
